// File: rtl/egg_timer_ctrl.sv
// Egg timer sequencer: loads a clamped MM:SS BCD preset, counts it down on 1 Hz ticks
// under start/stop control and raises a timed, flashing alarm when it reaches 00:00.
module egg_timer_ctrl #(
  parameter int ALARM_TICKS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1hz,
  input  logic [15:0] load_time,
  input  logic        load_btn,
  input  logic        start_btn,
  input  logic        stop_btn,
  output logic [15:0] display_time,
  output logic        running,
  output logic        alarm,
  output logic        alarm_flash,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    ALARM   = 2'b11
  } state_t;

  localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_TICKS);

  state_t      state_q, state_d;
  logic [15:0] time_q, time_d;
  logic        flash_q, flash_d;
  logic [7:0]  acnt_q, acnt_d;
  logic [7:0]  acntInc;
  logic        running_q, alarm_q;

  function automatic logic [15:0] clampBcd(input logic [15:0] t);
    logic [15:0] c;
    c[15:12] = (t[15:12] > 4'd5) ? 4'd5 : t[15:12];
    c[11:8]  = (t[11:8]  > 4'd9) ? 4'd9 : t[11:8];
    c[7:4]   = (t[7:4]   > 4'd5) ? 4'd5 : t[7:4];
    c[3:0]   = (t[3:0]   > 4'd9) ? 4'd9 : t[3:0];
    return c;
  endfunction

  // Only ever called with a non-zero value, so min_tens never underflows.
  function automatic logic [15:0] bcdDec(input logic [15:0] t);
    logic [15:0] d;
    d = t;
    if (d[3:0] != 4'd0) begin
      d[3:0] = d[3:0] - 4'd1;
    end else begin
      d[3:0] = 4'd9;
      if (d[7:4] != 4'd0) begin
        d[7:4] = d[7:4] - 4'd1;
      end else begin
        d[7:4] = 4'd5;
        if (d[11:8] != 4'd0) begin
          d[11:8] = d[11:8] - 4'd1;
        end else begin
          d[11:8]  = 4'd9;
          d[15:12] = d[15:12] - 4'd1;
        end
      end
    end
    return d;
  endfunction

  assign acntInc = acnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    flash_d = flash_q;
    acnt_d  = acnt_q;
    if (load_btn) begin
      time_d  = clampBcd(load_time);
      state_d = IDLE;
      flash_d = 1'b0;
      acnt_d  = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_btn && time_q != 16'h0000) state_d = RUNNING;
        end
        RUNNING: begin
          if (stop_btn) begin
            state_d = PAUSED;
          end else if (tick_1hz) begin
            time_d = (time_q == 16'h0000) ? 16'h0000 : bcdDec(time_q);
            if (time_d == 16'h0000) begin
              state_d = ALARM;
              acnt_d  = 8'd0;
              flash_d = 1'b0;
            end
          end
        end
        PAUSED: begin
          if (start_btn) state_d = RUNNING;
        end
        ALARM: begin
          if (stop_btn || start_btn) begin
            state_d = IDLE;
            flash_d = 1'b0;
            acnt_d  = 8'd0;
          end else if (tick_1hz) begin
            if (acntInc == ALARM_LIMIT) begin
              state_d = IDLE;
              flash_d = 1'b0;
              acnt_d  = 8'd0;
            end else begin
              acnt_d  = acntInc;
              flash_d = ~flash_q;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      time_q    <= 16'h0000;
      flash_q   <= 1'b0;
      acnt_q    <= 8'd0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      flash_q   <= flash_d;
      acnt_q    <= acnt_d;
      running_q <= (state_d == RUNNING);
      alarm_q   <= (state_d == ALARM);
    end
  end

  assign display_time = time_q;
  assign running      = running_q;
  assign alarm        = alarm_q;
  assign alarm_flash  = flash_q;
  assign state        = state_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Bench for egg_timer_ctrl: a seconds-based reference model is compared against the
// DUT every cycle, with directed literal checks pinning the model to known values.
module tb_egg_timer_ctrl;

  localparam int ALARM_TICKS = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_1hz = 1'b0;
  logic [15:0] load_time = 16'h0000;
  logic        load_btn = 1'b0;
  logic        start_btn = 1'b0;
  logic        stop_btn = 1'b0;
  logic [15:0] display_time;
  logic        running;
  logic        alarm;
  logic        alarm_flash;
  logic [1:0]  state;

  int assertCount = 0;
  int failCount = 0;
  bit checkEn = 1'b0;

  // Reference model: remaining time as plain seconds, mode 0 idle/1 run/2 pause/3 alarm.
  int mSec = 0;
  int mMode = 0;
  int mAcnt = 0;
  bit mFlash = 1'b0;

  egg_timer_ctrl #(.ALARM_TICKS(ALARM_TICKS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick_1hz(tick_1hz),
    .load_time(load_time),
    .load_btn(load_btn),
    .start_btn(start_btn),
    .stop_btn(stop_btn),
    .display_time(display_time),
    .running(running),
    .alarm(alarm),
    .alarm_flash(alarm_flash),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic int minInt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int clampSec(input logic [15:0] t);
    int mt, mo, st, so;
    mt = minInt(int'(t[15:12]), 5);
    mo = minInt(int'(t[11:8]), 9);
    st = minInt(int'(t[7:4]), 5);
    so = minInt(int'(t[3:0]), 9);
    return mt * 600 + mo * 60 + st * 10 + so;
  endfunction

  function automatic logic [15:0] toBcd(input int s);
    logic [15:0] b;
    b[15:12] = 4'(s / 600);
    b[11:8]  = 4'((s / 60) % 10);
    b[7:4]   = 4'((s % 60) / 10);
    b[3:0]   = 4'(s % 10);
    return b;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mMode = 0; mSec = 0; mAcnt = 0; mFlash = 1'b0;
    end else if (load_btn) begin
      mSec = clampSec(load_time); mMode = 0; mAcnt = 0; mFlash = 1'b0;
    end else if (mMode == 0) begin
      if (start_btn && mSec != 0) mMode = 1;
    end else if (mMode == 1) begin
      if (stop_btn) mMode = 2;
      else if (tick_1hz && mSec > 0) begin
        mSec = mSec - 1;
        if (mSec == 0) begin mMode = 3; mAcnt = 0; mFlash = 1'b0; end
      end
    end else if (mMode == 2) begin
      if (start_btn) mMode = 1;
    end else begin
      if (stop_btn || start_btn) begin
        mMode = 0; mAcnt = 0; mFlash = 1'b0;
      end else if (tick_1hz) begin
        mAcnt = mAcnt + 1;
        mFlash = !mFlash;
        if (mAcnt >= ALARM_TICKS) begin mMode = 0; mAcnt = 0; mFlash = 1'b0; end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_state", {14'b0, state}, 16'(mMode));
      checkOutput("model_display", display_time, toBcd(mSec));
      checkOutput("model_running", {15'b0, running}, {15'b0, mMode == 1});
      checkOutput("model_alarm", {15'b0, alarm}, {15'b0, mMode == 3});
      checkOutput("model_flash", {15'b0, alarm_flash}, {15'b0, mFlash});
    end
  end

  task automatic applyStimulus(input logic rstN, input logic ld, input logic [15:0] lt,
                               input logic st, input logic sp, input logic tk);
    @(negedge clk);
    rst_n = rstN;
    load_btn = ld;
    load_time = lt;
    start_btn = st;
    stop_btn = sp;
    tick_1hz = tk;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic loadStart(input logic [15:0] lt);
    applyStimulus(1'b1, 1'b1, lt, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic tickOnce();
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    idleCycle();
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    idleCycle();
    checkEn = 1'b1;
    checkOutput("reset_state", {14'b0, state}, 16'h0000);
    checkOutput("reset_display", display_time, 16'h0000);

    applyStimulus(1'b1, 1'b1, 16'h0130, 1'b0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("load_state", {14'b0, state}, 16'h0000);
    checkOutput("load_display", display_time, 16'h0130);
    checkOutput("load_alarm", {15'b0, alarm}, 16'h0000);

    applyStimulus(1'b1, 1'b1, 16'h7A6F, 1'b0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("clamp_display", display_time, 16'h5959);

    loadStart(16'h1000);
    tickOnce();
    checkOutput("borrow_min_tens", display_time, 16'h0959);
    loadStart(16'h0100);
    tickOnce();
    checkOutput("borrow_min_ones", display_time, 16'h0059);

    loadStart(16'h0005);
    tickOnce();
    tickOnce();
    checkOutput("pause_pre", display_time, 16'h0003);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    idleCycle();
    checkOutput("pause_state", {14'b0, state}, 16'h0002);
    checkOutput("pause_display", display_time, 16'h0003);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    tickOnce();
    checkOutput("resume_display", display_time, 16'h0002);

    loadStart(16'h0002);
    tickOnce();
    tickOnce();
    checkOutput("alarm_state", {14'b0, state}, 16'h0003);
    checkOutput("alarm_flag", {15'b0, alarm}, 16'h0001);
    checkOutput("alarm_display", display_time, 16'h0000);
    for (int i = 1; i < ALARM_TICKS; i++) begin
      tickOnce();
      checkOutput($sformatf("alarm_flash_%0d", i), {15'b0, alarm_flash}, 16'(i % 2));
    end
    tickOnce();
    checkOutput("timeout_state", {14'b0, state}, 16'h0000);
    checkOutput("timeout_alarm", {15'b0, alarm}, 16'h0000);
    checkOutput("timeout_flash", {15'b0, alarm_flash}, 16'h0000);

    loadStart(16'h0000);
    idleCycle();
    checkOutput("start_zero_state", {14'b0, state}, 16'h0000);

    loadStart(16'h0001);
    tickOnce();
    checkOutput("alarm1_state", {14'b0, state}, 16'h0003);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    idleCycle();
    checkOutput("alarm_stop_state", {14'b0, state}, 16'h0000);

    loadStart(16'h0043);
    tickOnce();
    checkOutput("pre_reset_display", display_time, 16'h0042);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("midrun_reset_state", {14'b0, state}, 16'h0000);
    checkOutput("midrun_reset_display", display_time, 16'h0000);

    begin
      logic lastTick = 1'b0;
      for (int c = 0; c < 5000; c++) begin
        logic tk, ld, st, sp, rn;
        logic [15:0] lt;
        tk = !lastTick && ($urandom_range(0, 99) < 35);
        ld = ($urandom_range(0, 99) < 2);
        st = !tk && ($urandom_range(0, 99) < 8);
        sp = ($urandom_range(0, 99) < 4);
        rn = !($urandom_range(0, 999) < 3);
        if ($urandom_range(0, 3) == 0) lt = 16'($urandom);
        else lt = {8'h00, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
        applyStimulus(rn, ld, lt, st, sp, tk);
        lastTick = tk;
      end
    end
    idleCycle();
    idleCycle();
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/egg_timer_ctrl.md
Name: egg_timer_ctrl

Overview:
Sequencing controller for the egg timer countdown. It loads the clamped MM:SS BCD value produced by the switch-validation stage. It counts that value down once per 1 Hz tick under start/stop control and raises a timed, flashing alarm at 00:00. Its outputs drive the 4-digit display path and the alarm LED/buzzer.

Parameters:
ALARM_TICKS, 10, number of 1 Hz ticks the alarm stays active before auto-return to IDLE (1..255)

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  synchronous active-low reset
tick_1hz  input  1  one-clk-wide enable pulse, 1 Hz
load_time  input  16  BCD {min_tens, min_ones, sec_tens, sec_ones} from switch validator
load_btn  input  1  one-clk pulse (debounced): load load_time
start_btn  input  1  one-clk pulse: start/resume
stop_btn  input  1  one-clk pulse: pause / acknowledge alarm
display_time  output  16  current BCD count
running  output  1  high in RUNNING
alarm  output  1  high in ALARM
alarm_flash  output  1  toggles each tick while in ALARM, else 0
state  output  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 ALARM

Behaviour:
- Reset (rst_n=0 at posedge) has priority over everything. It sets state=IDLE, display_time=16'h0000, running=0, alarm=0, alarm_flash=0, and alarm tick counter=0.
- All outputs are registered. A state change is visible in the cycle after the triggering posedge.
- Same-cycle priority among inputs: load_btn > stop_btn > start_btn > tick_1hz.
- Load clamping: each digit is clamped on capture. min_tens >5 becomes 5, min_ones >9 becomes 9, sec_tens >5 becomes 5, sec_ones >9 becomes 9. Per-digit, independent. Example: 16'hAB7C loads as 16'h5959.
- IDLE:
  - load_btn: capture the clamped load_time; stay in IDLE.
  - start_btn with display_time != 0: go to RUNNING.
  - start_btn with display_time == 0: ignored.
  - tick_1hz: ignored.
- RUNNING:
  - tick_1hz: BCD decrement by one second.
    - sec_ones 0 -> 9 with borrow.
    - sec_tens 0 -> 5 with borrow.
    - min_ones 0 -> 9 with borrow.
    - min_tens decrements.
  - If the decremented value is 0000: go to ALARM in the same update, with display 0000 and alarm counter=0.
  - stop_btn: go to PAUSED; no decrement that cycle, even if tick_1hz is also high.
  - load_btn: capture the clamped value and go to IDLE.
  - start_btn: no effect.
- PAUSED:
  - display_time is held.
  - start_btn: go to RUNNING. The first decrement occurs on the next tick_1hz after the start cycle.
  - load_btn: capture and go to IDLE.
  - stop_btn and tick_1hz: no effect.
- ALARM:
  - alarm=1; display_time held at 0000.
  - On each tick_1hz: alarm_flash toggles and the alarm counter increments. When the counter reaches ALARM_TICKS: go to IDLE, alarm_flash=0.
  - stop_btn or start_btn: go to IDLE immediately.
  - load_btn: capture and go to IDLE.
  - The first toggle makes alarm_flash=1.
- alarm_flash is forced to 0 outside ALARM.
- Wrap-around: display_time never decrements below 0000. The only way out of 0000 is a load.
- Maximum count is 59:59 (16'h5959), i.e. 3599 ticks.
- Reset mid-RUNNING or mid-ALARM returns to IDLE with 0000; no residual alarm counter.
- tick_1hz held high for multiple clks is not supported; the bench drives pulses only.

Test Plan:
- Reset/load: rst_n low 2 clks, then load_btn with load_time=16'h0130 -> state=00, display_time=16'h0130, alarm=0.
- Clamp: load_btn with load_time=16'h7A6F -> display_time=16'h5959.
- Borrow chain: load 16'h1000, start, 1 tick -> 16'h0959; load 16'h0100, start, 1 tick -> 16'h0059.
- Pause priority: load 16'h0005, start, 2 ticks -> 16'h0003. Then stop and tick in the same clk -> state=10, display stays 16'h0003. Start, 1 tick -> 16'h0002.
- Alarm timeout: load 16'h0002, start, 2 ticks -> state=11, alarm=1, display 0000. alarm_flash toggles 1,0,1,... on the next ticks. After ALARM_TICKS=10 ticks -> state=00, alarm=0, alarm_flash=0.
- Edge cases:
  - start in IDLE with 0000 -> stays IDLE.
  - stop during ALARM -> IDLE next clk.
  - rst_n low during RUNNING at 16'h0042 -> IDLE, 16'h0000.
